// File: rtl/seq_div.sv
// Multi-cycle radix-2 restoring integer divider with signed/unsigned modes,
// divide-by-zero flagging and valid/ready handshakes on operand and result sides.
module seq_div #(
    parameter int unsigned DATAWIDTH = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 div_zero
);
    localparam int unsigned CW = $clog2(DATAWIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [DATAWIDTH-1:0] dvd;    // dividend shifts out, quotient bits shift in
    logic [DATAWIDTH-1:0] dvs;
    logic [DATAWIDTH-1:0] prem;
    logic                 neg_q;
    logic                 neg_r;
    logic                 zero_p;

    logic                 sgn;
    logic [DATAWIDTH-1:0] abs_a;
    logic [DATAWIDTH-1:0] abs_b;
    logic [DATAWIDTH:0]   shifted;
    logic [DATAWIDTH:0]   trial;
    logic [DATAWIDTH-1:0] q_fix;
    logic [DATAWIDTH-1:0] r_fix;

    always_comb begin
        sgn     = SIGNED_EN && in_signed;
        abs_a   = (sgn && a[DATAWIDTH-1]) ? -a : a;
        abs_b   = (sgn && b[DATAWIDTH-1]) ? -b : b;
        shifted = {prem, dvd[DATAWIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        q_fix   = neg_q ? -dvd : dvd;
        r_fix   = neg_r ? -prem : prem;
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            prem      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_p    <= 1'b0;
            out_valid <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        prem <= '0;
                        if (b == '0) begin
                            dvd    <= a;
                            zero_p <= 1'b1;
                            state  <= FIX;
                        end else begin
                            dvd    <= abs_a;
                            dvs    <= abs_b;
                            neg_r  <= sgn && a[DATAWIDTH-1];
                            neg_q  <= sgn && (a[DATAWIDTH-1] ^ b[DATAWIDTH-1]);
                            zero_p <= 1'b0;
                            cnt    <= CW'(DATAWIDTH);
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Negative trial result means restore the shifted value.
                    if (trial[DATAWIDTH]) begin
                        prem <= shifted[DATAWIDTH-1:0];
                    end else begin
                        prem <= trial[DATAWIDTH-1:0];
                    end
                    dvd <= {dvd[DATAWIDTH-2:0], ~trial[DATAWIDTH]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero_p) begin
                        quot     <= '1;
                        rem      <= dvd;
                        div_zero <= 1'b1;
                    end else begin
                        quot     <= q_fix;
                        rem      <= r_fix;
                        div_zero <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
